// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the byte-serial data-memory/stack controller.
//   - default memory depth in bytes
//   - opcode encodings for the MEM-stage request types
//   - FSM state encoding
//   - is_write_op(): which opcodes store a word to memory
package mem_pkg;

   localparam int DEFAULT_DEPTH = 1024;

   localparam logic [5:0] OP_LW   = 6'b000101;
   localparam logic [5:0] OP_SW   = 6'b000111;
   localparam logic [5:0] OP_PUSH = 6'b001111;
   localparam logic [5:0] OP_POP  = 6'b010000;
   localparam logic [5:0] OP_CALL = 6'b001101;
   localparam logic [5:0] OP_RET  = 6'b001110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_e;

   function automatic logic is_write_op(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_PUSH) || (op == OP_CALL);
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage initiator for a byte-wide, little-endian data
// memory. Each accepted word request (LW/SW/PUSH/POP/CALL/RET) becomes four
// byte beats; the controller owns the stack pointer and returns results with
// a one-cycle response pulse.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   opcode, addr, wdata, pc    request payload, latched at acceptance
//   rsp_valid, rsp_err         one-cycle completion pulse and its error flag
//   rdata, ret_pc              LW/POP result, RET result (held until replaced)
//   sp                         current stack pointer
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   byte memory port (sync read)
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int SP_RESET = DEPTH - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [5:0]        opcode,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       pc,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rdata,
   output logic [31:0]       ret_pc,
   output logic [31:0]       sp,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);

   state_e            state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       word_q, word_d;
   logic [5:0]        op_q, op_d;
   logic              err_q, err_d;
   logic [23:0]       asm_q, asm_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       ret_pc_q, ret_pc_d;
   logic [31:0]       sp_q, sp_d;

   // Legality of the request currently on the inputs, judged against the
   // present sp so that a rejected PUSH/CALL never touches the stack pointer.
   logic req_bad;
   always_comb begin
      req_bad = 1'b0;
      case (opcode)
         OP_LW, OP_SW:     req_bad = (addr > LAST_WORD);
         OP_PUSH, OP_CALL: req_bad = (sp_q < 32'd4);
         OP_POP, OP_RET:   req_bad = (sp_q > LAST_WORD);
         default:          req_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      base_d    = base_q;
      word_d    = word_q;
      op_d      = op_q;
      err_d     = err_q;
      asm_d     = asm_q;
      rdata_d   = rdata_q;
      ret_pc_d  = ret_pc_q;
      sp_d      = sp_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d   = opcode;
               err_d  = req_bad;
               k_d    = 2'd0;
               word_d = (opcode == OP_CALL) ? (pc + 32'd1) : wdata;
               if (req_bad) begin
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
                  case (opcode)
                     OP_PUSH, OP_CALL: begin
                        // Pre-decrement: the word lands at the new top.
                        sp_d   = sp_q - 32'd4;
                        base_d = ADDR_W'(sp_q - 32'd4);
                     end
                     OP_POP, OP_RET: base_d = sp_q[ADDR_W-1:0];
                     default:        base_d = addr[ADDR_W-1:0];
                  endcase
               end
            end
         end

         ISSUE: begin
            mem_en   = 1'b1;
            mem_we   = is_write_op(op_q);
            mem_addr = base_q + {{(ADDR_W-2){1'b0}}, k_q};
            if (is_write_op(op_q)) begin
               mem_wdata = word_q[{k_q, 3'b000} +: 8];
            end
            // Synchronous memory: the byte for beat k-1 is on mem_rdata
            // during beat k.
            if (k_q != 2'd0) begin
               asm_d[{k_q - 2'd1, 3'b000} +: 8] = mem_rdata;
            end
            if (k_q == 2'd3) begin
               state_d = is_write_op(op_q) ? RESP : DRAIN;
            end else begin
               k_d = k_q + 2'd1;
            end
         end

         DRAIN: begin
            // Last read byte arrives here; publish the word on entry to RESP.
            state_d = RESP;
            if (op_q == OP_RET) begin
               ret_pc_d = {mem_rdata, asm_q};
            end else begin
               rdata_d = {mem_rdata, asm_q};
            end
            if (op_q != OP_LW) begin
               sp_d = sp_q + 32'd4;
            end
         end

         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         k_q      <= 2'd0;
         base_q   <= '0;
         word_q   <= '0;
         op_q     <= '0;
         err_q    <= 1'b0;
         asm_q    <= '0;
         rdata_q  <= '0;
         ret_pc_q <= '0;
         sp_q     <= 32'(SP_RESET);
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         base_q   <= base_d;
         word_q   <= word_d;
         op_q     <= op_d;
         err_q    <= err_d;
         asm_q    <= asm_d;
         rdata_q  <= rdata_d;
         ret_pc_q <= ret_pc_d;
         sp_q     <= sp_d;
      end
   end

   assign rdata  = rdata_q;
   assign ret_pc = ret_pc_q;
   assign sp     = sp_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a byte-wide synchronous memory
// model. Inputs change away from the rising edge; outputs are sampled on the
// falling edge.
module tb_mem_access_ctrl;
   import mem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  opcode;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rdata;
   logic [31:0] ret_pc;
   logic [31:0] sp;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   mem_access_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .opcode    (opcode),
      .addr      (addr),
      .wdata     (wdata),
      .pc        (pc),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rdata     (rdata),
      .ret_pc    (ret_pc),
      .sp        (sp),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory: write on the edge, registered read data next cycle.
   logic [7:0] mem_model [1024] = '{default: 8'h00};
   logic [7:0] mem_rd_q = 8'h00;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_model[mem_addr] <= mem_wdata;
         else        mem_rd_q <= mem_model[mem_addr];
      end
   end
   assign mem_rdata = mem_rd_q;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Per-transaction log filled by do_req.
   logic [9:0] b_addr [8];
   logic [7:0] b_data [8];
   logic       b_we   [8];
   int         n_beats;
   int         rsp_cyc;
   logic       rsp_err_seen;

   task automatic do_req(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] p);
      @(negedge clk);
      check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      opcode    = op;
      addr      = a;
      wdata     = wd;
      pc        = p;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n_beats      = 0;
      rsp_cyc      = 0;
      rsp_err_seen = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (mem_en && n_beats < 8) begin
            b_addr[n_beats] = mem_addr;
            b_data[n_beats] = mem_wdata;
            b_we[n_beats]   = mem_we;
            n_beats++;
         end
         if (rsp_valid) begin
            rsp_cyc      = i;
            rsp_err_seen = rsp_err;
            break;
         end
      end
      $display("[%0t] %s op=%b addr=%0d rsp_at=T+%0d err=%0b beats=%0d rdata=%h ret_pc=%h sp=%0d",
               $time, name, op, a, rsp_cyc, rsp_err_seen, n_beats, rdata, ret_pc, sp);
   endtask

   task automatic check_beats(input string name, input logic [9:0] base,
                              input logic [31:0] word, input logic we);
      logic [31:0] w;
      w = word;
      check({name, "_nbeats"}, n_beats, 32'd4);
      for (int k = 0; k < 4; k++) begin
         check({name, "_baddr"}, {22'b0, b_addr[k]}, {22'b0, base + 10'(k)});
         check({name, "_bwe"}, {31'b0, b_we[k]}, {31'b0, we});
         if (we) check({name, "_bdata"}, {24'b0, b_data[k]}, {24'b0, w[8*k +: 8]});
      end
   endtask

   task automatic check_err(input string name, input logic [31:0] exp_sp);
      check({name, "_lat"}, rsp_cyc, 32'd1);
      check({name, "_err"}, {31'b0, rsp_err_seen}, 32'd1);
      check({name, "_nbeats"}, n_beats, 32'd0);
      check({name, "_sp"}, sp, exp_sp);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int rsp_count;

   initial begin
      req_valid = 1'b0;
      opcode    = '0;
      addr      = '0;
      wdata     = '0;
      pc        = '0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Reset state, sampled while reset is still asserted.
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_sp", sp, 32'd1023);
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ret_pc", ret_pc, 32'd0);
      rst_n = 1'b1;

      // Store then load a word at address 8.
      do_req("sw8", OP_SW, 32'd8, 32'hDEADBEEF, 32'd0);
      check_beats("sw8", 10'd8, 32'hDEADBEEF, 1'b1);
      check("sw8_lat", rsp_cyc, 32'd5);
      check("sw8_err", {31'b0, rsp_err_seen}, 32'd0);
      check("sw8_mem", {mem_model[11], mem_model[10], mem_model[9], mem_model[8]}, 32'hDEADBEEF);
      do_req("lw8", OP_LW, 32'd8, 32'd0, 32'd0);
      check_beats("lw8", 10'd8, 32'd0, 1'b0);
      check("lw8_lat", rsp_cyc, 32'd6);
      check("lw8_rdata", rdata, 32'hDEADBEEF);

      // PUSH / POP.
      do_req("push", OP_PUSH, 32'd0, 32'h11223344, 32'd0);
      check_beats("push", 10'd1019, 32'h11223344, 1'b1);
      check("push_lat", rsp_cyc, 32'd5);
      check("push_sp", sp, 32'd1019);
      do_req("pop", OP_POP, 32'd0, 32'd0, 32'd0);
      check_beats("pop", 10'd1019, 32'd0, 1'b0);
      check("pop_lat", rsp_cyc, 32'd6);
      check("pop_rdata", rdata, 32'h11223344);
      check("pop_sp", sp, 32'd1023);

      // CALL / RET: return address is pc+1.
      do_req("call", OP_CALL, 32'd0, 32'hFFFFFFFF, 32'h40);
      check_beats("call", 10'd1019, 32'h41, 1'b1);
      check("call_sp", sp, 32'd1019);
      do_req("ret", OP_RET, 32'd0, 32'd0, 32'd0);
      check("ret_lat", rsp_cyc, 32'd6);
      check("ret_pc", ret_pc, 32'h41);
      check("ret_sp", sp, 32'd1023);
      check("ret_rdata_kept", rdata, 32'h11223344);

      // Rejected requests.
      do_req("pop_empty", OP_POP, 32'd0, 32'd0, 32'd0);
      check_err("pop_empty", 32'd1023);
      do_req("lw_range", OP_LW, 32'd1021, 32'd0, 32'd0);
      check_err("lw_range", 32'd1023);
      do_req("bad_op", 6'b111111, 32'd0, 32'd0, 32'd0);
      check_err("bad_op", 32'd1023);
      check("err_rdata_kept", rdata, 32'h11223344);
      check("err_ret_pc_kept", ret_pc, 32'h41);

      // Highest legal word address.
      do_req("sw_top", OP_SW, 32'd1020, 32'hCAFEF00D, 32'd0);
      check_beats("sw_top", 10'd1020, 32'hCAFEF00D, 1'b1);
      check("sw_top_err", {31'b0, rsp_err_seen}, 32'd0);
      do_req("lw_top", OP_LW, 32'd1020, 32'd0, 32'd0);
      check("lw_top_rdata", rdata, 32'hCAFEF00D);

      // req_valid held high: PUSH, then a POP waiting behind it.
      @(negedge clk);
      req_valid = 1'b1;
      opcode    = OP_PUSH;
      wdata     = 32'h0BADCAFE;
      @(posedge clk);
      #1 opcode = OP_POP;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check("hold_ready_low", {31'b0, req_ready}, 32'd0);
      end
      @(negedge clk);
      check("hold_ready_back", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("hold_second_en", {31'b0, mem_en}, 32'd1);
      check("hold_second_addr", {22'b0, mem_addr}, 32'd1019);
      check("hold_second_we", {31'b0, mem_we}, 32'd0);
      rsp_count = 0;
      for (int i = 0; i < 10 && rsp_count == 0; i++) begin
         @(negedge clk);
         if (rsp_valid) rsp_count++;
      end
      check("hold_pop_rsp", rsp_count, 32'd1);
      check("hold_pop_rdata", rdata, 32'h0BADCAFE);
      check("hold_pop_sp", sp, 32'd1023);

      // Reset in the middle of a store, with sp moved away from its reset value.
      do_req("push_pre", OP_PUSH, 32'd0, 32'hA5A5A5A5, 32'd0);
      check("push_pre_sp", sp, 32'd1019);
      @(negedge clk);
      req_valid = 1'b1;
      opcode    = OP_SW;
      addr      = 32'd16;
      wdata     = 32'h55667788;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_en_before", {31'b0, mem_en}, 32'd1);
      check("midrst_addr_before", {22'b0, mem_addr}, 32'd18);
      rst_n = 1'b0;
      #1;
      check("midrst_en", {31'b0, mem_en}, 32'd0);
      check("midrst_sp", sp, 32'd1023);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_ready", {31'b0, req_ready}, 32'd1);
      rsp_count = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) rsp_count++;
      end
      check("midrst_no_rsp", rsp_count, 32'd0);
      check("midrst_partial", {mem_model[19], mem_model[18], mem_model[17], mem_model[16]}, 32'h00007788);
      $display("[%0t] midrst SW addr=16 aborted after beat 1, sp=%0d", $time, sp);
      do_req("lw_after", OP_LW, 32'd16, 32'd0, 32'd0);
      check("lw_after_lat", rsp_cyc, 32'd6);
      check("lw_after_rdata", rdata, 32'h00007788);

      // Fill the stack down to sp=3, then PUSH/CALL must be rejected.
      for (int i = 1; i <= 255; i++) begin
         do_req("fill", OP_PUSH, 32'd0, 32'(i), 32'd0);
      end
      check("fill_sp", sp, 32'd3);
      do_req("push_ovf", OP_PUSH, 32'd0, 32'h12345678, 32'd0);
      check_err("push_ovf", 32'd3);
      do_req("call_ovf", OP_CALL, 32'd0, 32'd0, 32'h100);
      check_err("call_ovf", 32'd3);
      do_req("pop_low", OP_POP, 32'd0, 32'd0, 32'd0);
      check_beats("pop_low", 10'd3, 32'd0, 1'b0);
      check("pop_low_rdata", rdata, 32'd255);
      check("pop_low_sp", sp, 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog in case the DUT stalls outside a bounded wait.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory/stack interface: a CPU MEM-stage controller that turns one word-level request into four byte-serial accesses on a byte-wide, little-endian data memory.
- Request types: LW, SW, PUSH, POP, CALL, RET.
- Owns the stack pointer (SP).
- Returns the assembled load/pop word or the return PC to the pipeline through a single-cycle response pulse.

Parameters:
- DEPTH, 1024, memory size in bytes.
- ADDR_W, 10, memory address width, equal to clog2(DEPTH).
- SP_RESET, 1023, SP value after reset (empty stack).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- opcode  in  6  operation: LW 000101, SW 000111, PUSH 001111, POP 010000, CALL 001101, RET 001110.
- addr  in  32  byte address for LW/SW.
- wdata  in  32  store/push data.
- pc  in  32  current PC for CALL.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid; the operation was rejected.
- rdata  out  32  LW/POP result; holds its value until the next LW/POP completes.
- ret_pc  out  32  RET result; holds its value until the next RET completes.
- sp  out  32  current stack pointer.
- mem_en  out  1  byte access strobe.
- mem_we  out  1  write enable, valid when mem_en is high.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; synchronous, valid in the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async assert, sync deassert by the reset source):
  - state=IDLE, sp=SP_RESET.
  - mem_en, mem_we, mem_addr and mem_wdata = 0.
  - rsp_valid and rsp_err = 0.
  - rdata and ret_pc = 0.
  - req_ready = 1.
- Acceptance: the request is taken on the rising edge where req_valid && req_ready; opcode, addr, wdata and pc are latched there. That edge is T.
- Base address and SP, decided at acceptance:
  - LW/SW: base = addr[ADDR_W-1:0].
  - PUSH/CALL: sp <= sp-4 at T; base = the new sp.
  - POP/RET: base = sp; sp <= sp+4 at the edge that enters RESP.
- Write data: PUSH and SW write wdata; CALL writes pc+1 (32-bit wrap).
- FSM states: IDLE, ISSUE, DRAIN, RESP.
  - IDLE -> ISSUE on acceptance of a legal, in-range request.
  - ISSUE lasts 4 cycles (T+1..T+4) with beat counter k=0..3: mem_en=1, mem_addr=base+k.
    - Writes: mem_we=1, mem_wdata = word byte k (bits 8k+7:8k), so the LSB goes to the lowest address.
  - ISSUE -> RESP after k=3 for writes.
  - ISSUE -> DRAIN after k=3 for reads (LW/POP/RET). Read byte k is captured into assembly byte k on the edge after beat k; DRAIN (T+5) captures byte 3.
  - RESP: rsp_valid=1 for one cycle. rdata (LW/POP) or ret_pc (RET) is updated on entry to RESP. RESP -> IDLE.
- Latency, acceptance to rsp_valid cycle: writes T+5, reads T+6.
- Throughput: no back-to-back overlap; req_ready is 0 outside IDLE.
- The response cannot be back-pressured.
- Error cases: the request is consumed and no mem_en is issued. sp is unchanged (no pre-decrement). RESP occurs at T+1 with rsp_valid=1, rsp_err=1, and rdata/ret_pc unchanged.
  - LW/SW with addr > DEPTH-4.
  - PUSH/CALL with sp < 4 (overflow).
  - POP/RET with sp > DEPTH-4 (underflow/empty).
  - Unrecognised opcode.
- Alignment: no alignment is required; base+k never exceeds DEPTH-1 because of the range checks.
- Reset mid-operation: all activity aborts immediately and sp returns to SP_RESET. No response is produced for the aborted request. Bytes already written stay in memory (partial word).
- rsp_err = 0 whenever rsp_valid = 0.

Decomposition:
- Package mem_pkg:
  - opcode localparams: OP_LW, OP_SW, OP_PUSH, OP_POP, OP_CALL, OP_RET;
  - FSM state encoding: IDLE, ISSUE, DRAIN, RESP;
  - default DEPTH.
- Single module; the beat counter, byte mux and byte assembler are small enough to stay inline. No sub-module.

Test Plan:
- SW addr=8, wdata=0xDEADBEEF:
  - mem writes at T+1..T+4 = (8,EF), (9,BE), (10,AD), (11,DE);
  - rsp_valid at T+5, rsp_err=0.
  - Then LW addr=8 from a memory model -> rdata=0xDEADBEEF with rsp_valid at T+6.
- After reset, PUSH 0x11223344:
  - sp=1019; bytes 44,33,22,11 written to 1019..1022.
  - Then POP -> rdata=0x11223344, sp=1023.
- CALL pc=0x40 -> bytes 41,00,00,00 written at 1019..1022, sp=1019. Then RET -> ret_pc=0x41, sp=1023, rsp_valid at T+6.
- Error cases:
  - POP immediately after reset (sp=1023) -> rsp_valid and rsp_err at T+1, no mem_en, sp=1023.
  - LW addr=1021 -> same error response, no mem_en.
  - opcode 6'b111111 -> same error response, no mem_en.
- Assert rst_n low during SW after beat k=1 -> mem_en=0 immediately, sp=1023, req_ready=1 after release, no rsp_valid. The next LW works normally.
- Hold req_valid high across a PUSH -> req_ready is 0 from T+1 to T+5, and the second request is accepted on the first edge back in IDLE.
